iram_bit_ctrl: RTL and testbench
================================

# iram_bit_ctrl

Parametrised 8051-family internal data memory controller: lower RAM, optional upper RAM (8052 style, indirect only) and SFR backing storage behind one request/ready port. Supports byte and bit access, with bit writes performed as an explicit two-cycle read-modify-write. Sits between the CPU execute unit and on-chip storage. Replaces the single-cycle byte/bit RAM with a handshaked, error-reporting block.

## Interface
- ADDR_WIDTH, 8, width of addr; fixed 8 for 8051 addressing, kept as a parameter for the upper-RAM mapping.
- RAM_DEPTH, 256, internal RAM bytes: 128 = no upper RAM, 256 = upper RAM at 0x80–0xFF (indirect only).
- BIT_BASE, 8'h20, first byte of the 16-byte bit-addressable RAM region.
- SFR_BASE, 8'h80, first SFR address; direct addresses >= SFR_BASE select SFR storage (128 bytes).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled only on an edge where ready=1.
- ready  out  1  block idle, can accept req.
- addr  in  ADDR_WIDTH  byte address, or bit address when is_bit=1.
- we  in  1  1 = write, 0 = read.
- is_bit  in  1  bit access.
- indirect  in  1  byte access via @Ri/SP; addr >= 0x80 targets upper RAM, not SFR.
- wdata  in  8  byte write data.
- wbit  in  1  bit write data.
- rdata  out  8  byte read data, valid while rvalid=1.
- rbit  out  1  bit read data, valid while rvalid=1.
- rvalid  out  1  one-cycle pulse: read data valid.
- err  out  1  one-cycle pulse: illegal request rejected.

## Operation
- States: IDLE, BYTE_RD, RMW_RD, RMW_WR. ready=1 only in IDLE.
- Byte map: direct addr < SFR_BASE → RAM[addr]; direct addr >= SFR_BASE → SFR[addr-SFR_BASE]; indirect → RAM[addr].
- Bit map: bit addr < 0x80 → RAM[BIT_BASE + addr[6:3]] bit addr[2:0]; bit addr >= 0x80 → SFR byte {addr[7:3],3'b000} bit addr[2:0] (only 8-aligned SFRs are bit-addressable by construction).
- Accept in IDLE with req=1:
  - Illegal (is_bit & indirect, or indirect & addr >= RAM_DEPTH): no storage change, err=1 next cycle, stay IDLE.
  - Byte write: storage written on accept edge, stay IDLE, no rvalid.
  - Byte read or bit read: latch address, go BYTE_RD; next edge loads rdata (byte read) or rbit (bit read) and leaves the other output unchanged, rvalid=1, return IDLE.
  - Bit write: go RMW_RD; next edge latches target byte into temp, go RMW_WR; next edge writes temp with bit replaced by latched wbit, return IDLE.
- Request fields (addr, we, is_bit, indirect, wdata, wbit) are latched on accept; later changes have no effect.
- req while ready=0 is ignored, not queued; requester must re-present it.
- Storage contents are not cleared by reset; initialised to 0x00 at power-up only.

## Timing
- Reset (async assert): state IDLE, ready=1, rdata=8'h00, rbit=0, rvalid=0, err=0.
- Reset asserted in RMW_RD/RMW_WR/BYTE_RD: operation aborted, no byte written, no rvalid.
- Byte write: 1 cycle, ready never drops.
- Read: accept edge T, rvalid high in cycle T+1..T+2 (after edge T+1), ready=0 between edges T and T+1; next req accepted at edge T+2 earliest (back-to-back reads every 2 cycles).
- Bit write: ready=0 for 2 cycles after accept; written byte visible to a read accepted at or after the edge that returns to IDLE.
- rvalid and err are never high in the same cycle; each is a 1-cycle pulse.
- rdata/rbit hold their last value when rvalid=0.

## Test plan
- Byte write RAM[0x30]=0xA5, then read 0x30 -> rvalid one cycle after BYTE_RD, rdata=0xA5; ready low exactly 1 cycle.
- RAM[0x21]=0x00; bit write addr 0x0B, wbit=1 -> ready low 2 cycles, byte read 0x21 returns 0x08; bit read 0x0B -> rbit=1.
- SFR bit write addr 0xE7 wbit=1 on SFR 0xE0=0x00 -> byte read direct 0xE0 returns 0x80; bit read 0xE7 -> rbit=1.
- RAM_DEPTH=256: indirect write 0x90=0x3C, direct write 0x90=0x11 -> indirect read 0x90=0x3C, direct read 0x90=0x11. RAM_DEPTH=128: indirect read 0x90 -> err pulse, no rvalid, ready stays 1.
- Bit write 0x0B issued, reset asserted during RMW_WR -> all outputs at reset values, RAM[0x21] unchanged.
- req held high while ready=0 during bit write, with different addr -> only original write executed; held req accepted on return to IDLE.

Source files
------------

// File: rtl/iram_bit_ctrl.sv
// rtl/iram_bit_ctrl.sv - 8051 internal data memory controller: lower/upper RAM and SFR storage, byte and bit access
module iram_bit_ctrl #(
  parameter int         ADDR_WIDTH = 8,
  parameter int         RAM_DEPTH  = 256,
  parameter logic [7:0] BIT_BASE   = 8'h20,
  parameter logic [7:0] SFR_BASE   = 8'h80
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  is_bit,
  input  logic                  indirect,
  input  logic [7:0]            wdata,
  input  logic                  wbit,
  output logic [7:0]            rdata,
  output logic                  rbit,
  output logic                  rvalid,
  output logic                  err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, BYTE_RD, RMW_RD, RMW_WR} state_t;

  state_t state, state_nxt;

  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] sfr [128];

  logic [7:0] a8;
  logic       dec_sfr;
  logic [7:0] dec_byte;
  logic       illegal;
  logic       accept;

  logic       t_sfr;
  logic [7:0] t_byte;
  logic [2:0] t_bit;
  logic       t_isbit;
  logic       t_wbit;
  logic [7:0] temp;
  logic [7:0] merged;
  logic [7:0] rd_byte;

  logic       mem_we;
  logic       mem_sfr;
  logic [7:0] mem_byte;
  logic [7:0] mem_data;

  assign a8     = addr[7:0];
  assign ready  = (state == IDLE);
  assign accept = ready & req;

  // Bit addresses below 0x80 hit the 16-byte bit region; above, only 8-aligned SFRs.
  always_comb begin
    dec_sfr  = 1'b0;
    dec_byte = a8;
    if (is_bit) begin
      if (a8[7]) begin
        dec_sfr  = 1'b1;
        dec_byte = {a8[7:3], 3'b000};
      end else begin
        dec_byte = BIT_BASE + {4'b0000, a8[6:3]};
      end
    end else if (!indirect && (a8 >= SFR_BASE)) begin
      dec_sfr = 1'b1;
    end
  end

  assign illegal = indirect & (is_bit | (32'(addr) >= 32'(RAM_DEPTH)));

  assign rd_byte = t_sfr ? sfr[7'(t_byte - SFR_BASE)] : ram[RAM_AW'(t_byte)];

  always_comb begin
    merged        = temp;
    merged[t_bit] = t_wbit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_sfr   = t_sfr;
    mem_byte  = t_byte;
    mem_data  = merged;
    case (state)
      IDLE: begin
        if (req && !illegal) begin
          if (we && !is_bit) begin
            mem_we   = 1'b1;
            mem_sfr  = dec_sfr;
            mem_byte = dec_byte;
            mem_data = wdata;
          end else if (we) begin
            state_nxt = RMW_RD;
          end else begin
            state_nxt = BYTE_RD;
          end
        end
      end
      BYTE_RD: state_nxt = IDLE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR: begin
        mem_we    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata   <= 8'h00;
      rbit    <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      t_sfr   <= 1'b0;
      t_byte  <= 8'h00;
      t_bit   <= 3'd0;
      t_isbit <= 1'b0;
      t_wbit  <= 1'b0;
      temp    <= 8'h00;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (accept) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          t_sfr   <= dec_sfr;
          t_byte  <= dec_byte;
          t_bit   <= a8[2:0];
          t_isbit <= is_bit;
          t_wbit  <= wbit;
        end
      end
      if (state == BYTE_RD) begin
        rvalid <= 1'b1;
        if (t_isbit) begin
          rbit <= rd_byte[t_bit];
        end else begin
          rdata <= rd_byte;
        end
      end
      if (state == RMW_RD) begin
        temp <= rd_byte;
      end
    end
  end

  // Storage has no reset: contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      if (mem_sfr) begin
        sfr[7'(mem_byte - SFR_BASE)] <= mem_data;
      end else begin
        ram[RAM_AW'(mem_byte)] <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_iram_bit_ctrl.sv
// tb/tb_iram_bit_ctrl.sv - scoreboard bench for iram_bit_ctrl (256-byte and 128-byte instances)
module tb_iram_bit_ctrl;

  typedef struct {
    int         kind;   // 0 byte read, 1 bit read, 2 error
    logic [7:0] data;
    logic       b;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       req_a, req_b;
  logic       we, is_bit, indirect, wbit;
  logic [7:0] addr, wdata;

  logic       ready_a, rbit_a, rvalid_a, err_a;
  logic [7:0] rdata_a;
  logic       ready_b, rbit_b, rvalid_b, err_b;
  logic [7:0] rdata_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int tests = 0;
  int fails = 0;

  iram_bit_ctrl #(.RAM_DEPTH(256)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .ready(ready_a), .addr(addr),
    .we(we), .is_bit(is_bit), .indirect(indirect), .wdata(wdata), .wbit(wbit),
    .rdata(rdata_a), .rbit(rbit_a), .rvalid(rvalid_a), .err(err_a)
  );

  iram_bit_ctrl #(.RAM_DEPTH(128)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .ready(ready_b), .addr(addr),
    .we(we), .is_bit(is_bit), .indirect(indirect), .wdata(wdata), .wbit(wbit),
    .rdata(rdata_b), .rbit(rbit_b), .rvalid(rvalid_b), .err(err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rvalid_a || err_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_output", {30'd0, rvalid_a, err_a}, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_rvalid_err_exclusive", {31'd0, rvalid_a & err_a}, 32'd0);
        case (e_a.kind)
          0: chk("a_byte_read", {23'd0, rvalid_a, rdata_a}, {23'd0, 1'b1, e_a.data});
          1: chk("a_bit_read", {30'd0, rvalid_a, rbit_a}, {30'd0, 1'b1, e_a.b});
          default: chk("a_err_pulse", {30'd0, err_a, rvalid_a}, 32'd2);
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (rvalid_b || err_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_output", {30'd0, rvalid_b, err_b}, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        case (e_b.kind)
          0: chk("b_byte_read", {23'd0, rvalid_b, rdata_b}, {23'd0, 1'b1, e_b.data});
          1: chk("b_bit_read", {30'd0, rvalid_b, rbit_b}, {30'd0, 1'b1, e_b.b});
          default: chk("b_err_pulse", {30'd0, err_b, rvalid_b}, 32'd2);
        endcase
      end
    end
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  // kind: -1 no response expected, else pushed to the scoreboard before issue
  task automatic op(input int d, input logic w, input logic b, input logic ind,
                    input logic [7:0] ad, input logic [7:0] wd, input logic wb,
                    input int kind, input logic [7:0] ed, input logic eb,
                    input int busy_exp, input string name);
    int n;
    int c;
    exp_t x;
    n = 0;
    @(negedge clock);
    while (!rdy(d) && n < 20) begin
      n++;
      @(negedge clock);
    end
    if (n >= 20) chk({name, "_wait_ready"}, 32'd0, 32'd1);
    if (kind >= 0) begin
      x.kind = kind;
      x.data = ed;
      x.b    = eb;
      if (d == 0) q_a.push_back(x);
      else q_b.push_back(x);
    end
    we = w; is_bit = b; indirect = ind; addr = ad; wdata = wd; wbit = wb;
    if (d == 0) req_a = 1'b1;
    else req_b = 1'b1;
    @(posedge clock);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    c = 0;
    @(negedge clock);
    while (!rdy(d) && c < 10) begin
      c++;
      @(negedge clock);
    end
    chk({name, "_busy_cycles"}, c, busy_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t x;
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; is_bit = 1'b0; indirect = 1'b0; wbit = 1'b0;
    addr = 8'h00; wdata = 8'h00;
    repeat (3) @(negedge clock);
    chk("reset_ready", {31'd0, ready_a}, 32'd1);
    chk("reset_rdata", {24'd0, rdata_a}, 32'd0);
    chk("reset_rbit", {31'd0, rbit_a}, 32'd0);
    chk("reset_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("reset_err", {31'd0, err_a}, 32'd0);
    reset = 1'b1;

    // byte write / read
    op(0, 1, 0, 0, 8'h30, 8'hA5, 0, -1, 8'h00, 0, 0, "wr30");
    op(0, 0, 0, 0, 8'h30, 8'h00, 0,  0, 8'hA5, 0, 1, "rd30");
    op(0, 0, 0, 0, 8'h30, 8'h00, 0,  0, 8'hA5, 0, 1, "rd30_again");

    // RAM bit write into bit region
    op(0, 1, 0, 0, 8'h21, 8'h00, 0, -1, 8'h00, 0, 0, "wr21");
    op(0, 1, 0, 0, 8'h24, 8'h00, 0, -1, 8'h00, 0, 0, "wr24");
    op(0, 1, 1, 0, 8'h0B, 8'h00, 1, -1, 8'h00, 0, 2, "bw0b");
    op(0, 0, 0, 0, 8'h21, 8'h00, 0,  0, 8'h08, 0, 1, "rd21");
    op(0, 0, 1, 0, 8'h0B, 8'h00, 0,  1, 8'h00, 1, 1, "br0b");
    op(0, 0, 1, 0, 8'h0A, 8'h00, 0,  1, 8'h00, 0, 1, "br0a");

    // SFR bit write
    op(0, 1, 0, 0, 8'hE0, 8'h00, 0, -1, 8'h00, 0, 0, "wrE0");
    op(0, 1, 1, 0, 8'hE7, 8'h00, 1, -1, 8'h00, 0, 2, "bwE7");
    op(0, 0, 0, 0, 8'hE0, 8'h00, 0,  0, 8'h80, 0, 1, "rdE0");
    op(0, 0, 1, 0, 8'hE7, 8'h00, 0,  1, 8'h00, 1, 1, "brE7");

    // upper RAM versus SFR at the same address
    op(0, 1, 0, 1, 8'h90, 8'h3C, 0, -1, 8'h00, 0, 0, "iwr90");
    op(0, 1, 0, 0, 8'h90, 8'h11, 0, -1, 8'h00, 0, 0, "dwr90");
    op(0, 0, 0, 1, 8'h90, 8'h00, 0,  0, 8'h3C, 0, 1, "ird90");
    op(0, 0, 0, 0, 8'h90, 8'h00, 0,  0, 8'h11, 0, 1, "drd90");

    // illegal: indirect bit access
    op(0, 0, 1, 1, 8'h0B, 8'h00, 0,  2, 8'h00, 0, 0, "a_ind_bit");

    // 128-byte instance: legal access and upper-RAM rejection
    op(1, 1, 0, 0, 8'h30, 8'h5A, 0, -1, 8'h00, 0, 0, "b_wr30");
    op(1, 0, 0, 0, 8'h30, 8'h00, 0,  0, 8'h5A, 0, 1, "b_rd30");
    op(1, 0, 0, 1, 8'h90, 8'h00, 0,  2, 8'h00, 0, 0, "b_ird90");

    // req held through a bit write with changed fields
    @(negedge clock);
    x.kind = 0; x.data = 8'h18; x.b = 1'b0;
    q_a.push_back(x);
    we = 1'b1; is_bit = 1'b1; indirect = 1'b0; addr = 8'h0C; wbit = 1'b1; wdata = 8'hFF;
    req_a = 1'b1;
    @(posedge clock);
    #1;
    we = 1'b0; is_bit = 1'b0; addr = 8'h21; wbit = 1'b0;
    n = 0;
    @(negedge clock);
    while (!ready_a && n < 10) begin
      n++;
      @(negedge clock);
    end
    chk("held_busy_cycles", n, 32'd2);
    @(posedge clock);
    #1;
    req_a = 1'b0;
    op(0, 0, 0, 0, 8'h24, 8'h00, 0,  0, 8'h00, 0, 1, "rd24_untouched");
    op(0, 0, 0, 0, 8'h21, 8'h00, 0,  0, 8'h18, 0, 1, "rd21_pre_reset");

    // reset during RMW_WR aborts the bit write
    @(negedge clock);
    we = 1'b1; is_bit = 1'b1; indirect = 1'b0; addr = 8'h0B; wbit = 1'b0;
    req_a = 1'b1;
    @(posedge clock);
    #1;
    req_a = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rmw_reset_ready", {31'd0, ready_a}, 32'd1);
    chk("rmw_reset_rdata", {24'd0, rdata_a}, 32'd0);
    chk("rmw_reset_rbit", {31'd0, rbit_a}, 32'd0);
    chk("rmw_reset_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("rmw_reset_err", {31'd0, err_a}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    op(0, 0, 0, 0, 8'h21, 8'h00, 0,  0, 8'h18, 0, 1, "rd21_post_reset");

    repeat (5) @(negedge clock);
    chk("a_scoreboard_drained", q_a.size(), 32'd0);
    chk("b_scoreboard_drained", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
